// File: rtl/sincos_mix_decimator.sv
// sincos_mix_decimator
//   Pairs up two CORDIC result streams (A and B). For each accepted pair it
//   forms the averaged sine term (sin_A + sin_B) / 2, truncated toward zero.
//   It keeps one sample out of every DECIM accepted pairs. Kept samples go
//   through a 2-entry FIFO to an AXI-Stream style master port.
//   Misaligned input valids, dropped samples and a saturating drop count are
//   reported as sticky status.
//
// Ports
//   cordic_clk            clock, rising edge
//   RSTN                  asynchronous active-low reset
//   a_tvalid / a_tdata    stream A, {sin, cos}, signed, sin in upper half
//   b_tvalid / b_tdata    stream B, same format
//   m_tvalid / m_tready   output handshake
//   m_tdata               decimated mixed sample (signed, DW bits)
//   err_clr               one-cycle clear of align_err / overrun / drop_cnt
//   align_err             sticky: a_tvalid and b_tvalid disagreed
//   overrun               sticky: a sample was dropped on a full FIFO
//   drop_cnt              dropped-sample count, saturates at 255
module sincos_mix_decimator #(
  parameter int DECIM = 5,
  parameter int DW    = 16
) (
  input  logic            cordic_clk,
  input  logic            RSTN,
  input  logic            a_tvalid,
  input  logic [2*DW-1:0] a_tdata,
  input  logic            b_tvalid,
  input  logic [2*DW-1:0] b_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [DW-1:0]   m_tdata,
  input  logic            err_clr,
  output logic            align_err,
  output logic            overrun,
  output logic [7:0]      drop_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [7:0] LAST_PHASE = 8'(DECIM - 1);

  // Sum in DW+1 bits so it cannot overflow. Negative odd sums get +1 before
  // the arithmetic shift, which turns floor division into truncation toward
  // zero. The halved value always fits back into DW bits.
  function automatic logic signed [DW-1:0] mix_half(
    input logic signed [DW-1:0] x,
    input logic signed [DW-1:0] y
  );
    logic signed [DW:0] s;
    s = $signed({x[DW-1], x}) + $signed({y[DW-1], y});
    if (s[DW] && s[0]) s = s + $signed({{DW{1'b0}}, 1'b1});
    s = s >>> 1;
    return s[DW-1:0];
  endfunction

  logic [0:0]           state_q, state_d;
  logic [7:0]           phase_q, phase_d;
  logic signed [DW-1:0] mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 align_err_q, align_err_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic signed [DW-1:0] sin_a, sin_b, mix;
  logic [7:0]           phase_cur;
  logic                 accept, mismatch, capture, rd, wr, drop;
  logic                 unused_cos;

  assign sin_a      = a_tdata[2*DW-1:DW];
  assign sin_b      = b_tdata[2*DW-1:DW];
  assign unused_cos = ^{a_tdata[DW-1:0], b_tdata[DW-1:0]};
  assign mix        = mix_half(sin_a, sin_b);

  always_comb begin
    accept    = a_tvalid & b_tvalid;
    mismatch  = a_tvalid ^ b_tvalid;
    // In IDLE the next accepted pair is phase 0 by definition.
    phase_cur = (state_q == S_IDLE) ? 8'd0 : phase_q;
    capture   = accept && (phase_cur == LAST_PHASE);
    rd        = (cnt_q != 2'd0) && m_tready;
    // A full FIFO can still take a write when its head leaves this cycle.
    wr        = capture && ((cnt_q != 2'd2) || rd);
    drop      = capture && (cnt_q == 2'd2) && !rd;

    state_d = state_q;
    phase_d = phase_q;
    if (accept) begin
      state_d = S_RUN;
      phase_d = (phase_cur == LAST_PHASE) ? 8'd0 : phase_cur + 8'd1;
    end

    wr_ptr_d = wr ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = rd ? ~rd_ptr_q : rd_ptr_q;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Set/increment events take priority over a same-cycle clear.
    align_err_d = mismatch ? 1'b1 : (err_clr ? 1'b0 : align_err_q);
    overrun_d   = drop     ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    if (drop)
      drop_cnt_d = err_clr ? 8'd1 : ((drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1);
    else
      drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
  end

  always_ff @(posedge cordic_clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      phase_q     <= 8'd0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      align_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      if (wr) mem_q[wr_ptr_q] <= mix;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      align_err_q <= align_err_d;
      overrun_q   <= overrun_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_tvalid  = (cnt_q != 2'd0);
  assign m_tdata   = mem_q[rd_ptr_q];
  assign align_err = align_err_q;
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/sincos_mix_decimator.md
SINCOS_MIX_DECIMATOR -- requirements
Module: sincos_mix_decimator

Interface
REQ-001 Parameter DECIM, default 5, SHALL set the number of accepted input pairs per output sample (legal 1..255).
REQ-002 Parameter DW, default 16, SHALL set the width of each sin/cos field and of the output sample.
REQ-003 cordic_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RSTN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 a_tvalid  input  1  SHALL mark a valid CORDIC result on stream A.
REQ-006 a_tdata  input  2*DW  SHALL carry {sin, cos} of stream A, signed two's complement, sin in the upper half.
REQ-007 b_tvalid  input  1  SHALL mark a valid CORDIC result on stream B.
REQ-008 b_tdata  input  2*DW  SHALL carry {sin, cos} of stream B, same format as a_tdata.
REQ-009 m_tvalid  output  1  SHALL indicate m_tdata holds a decimated sample.
REQ-010 m_tready  input  1  SHALL indicate the downstream sink accepts the sample.
REQ-011 m_tdata  output  DW  SHALL carry the signed mixed sample.
REQ-012 err_clr  input  1  SHALL be a synchronous one-cycle clear of align_err, overrun and drop_cnt.
REQ-013 align_err  output  1  SHALL be a sticky flag for a tvalid mismatch between A and B.
REQ-014 overrun  output  1  SHALL be a sticky flag for a sample dropped on a full output buffer.
REQ-015 drop_cnt  output  8  SHALL count dropped samples, saturating at 255.

Function
REQ-016 A pair SHALL be accepted only in a cycle where a_tvalid=1 and b_tvalid=1; the block has no input ready signal and never back-pressures.
REQ-017 mix SHALL be computed as a (DW+1)-bit signed sum of sin_A and sin_B, divided by 2 with truncation toward zero: add 1 before the arithmetic right shift when the sum is negative and odd. The result always fits in DW bits; cos fields are ignored.
REQ-018 The FSM SHALL have two states. IDLE is entered on reset. IDLE -> RUN on the first accepted pair, and that pair counts as phase 0. RUN holds until reset.
REQ-019 Phase counter behaviour:
- counts accepted pairs 0..DECIM-1 and wraps to 0;
- when an accepted pair arrives with the counter at DECIM-1, that pair's mix SHALL be captured;
- with DECIM=1, every pair is captured.
REQ-020 Captured samples SHALL enter a 2-entry FIFO. m_tvalid SHALL rise on the cycle after capture, so latency is 1 cycle from the capturing pair to m_tvalid.
REQ-021 Output handshake:
- a transfer occurs when m_tvalid=1 and m_tready=1;
- m_tdata SHALL be the FIFO head;
- m_tdata and m_tvalid SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-022 FIFO full at capture, no read in that cycle: the sample SHALL be dropped, overrun set to 1, and drop_cnt incremented (saturating).
REQ-023 FIFO full at capture, with a transfer in the same cycle: the write SHALL be accepted, with no drop.
REQ-024 A cycle with a_tvalid XOR b_tvalid = 1:
- SHALL set align_err;
- SHALL NOT advance the phase counter;
- SHALL NOT change the FSM state.
REQ-025 err_clr=1 SHALL clear align_err, overrun and drop_cnt. If a set or increment event occurs in the same cycle, the event SHALL win: flag = 1, drop_cnt = 1.
REQ-026 FIFO ordering SHALL be strict first-in first-out. Occupancy SHALL never exceed 2.

Reset
REQ-027 RSTN=0 SHALL immediately force the following, regardless of clock:
- FSM = IDLE, phase counter = 0, FIFO empty;
- m_tvalid = 0, m_tdata = 0;
- align_err = 0, overrun = 0, drop_cnt = 0.
REQ-028 Assertion of RSTN mid-transfer SHALL discard all buffered samples. After release, the first accepted pair SHALL be phase 0.
REQ-029 Release of RSTN SHALL be synchronous to cordic_clk. No output SHALL change before the first rising edge after release.

Verification
REQ-030 Decimation check (DECIM=5, m_tready=1):
- stimulus: 10 consecutive pairs with sin_A = 100*k and sin_B = 0, k = 0..9;
- required: exactly 2 transfers with m_tdata = 200 then 450, each m_tvalid 1 cycle after pairs k=4 and k=9.
REQ-031 Rounding check (DECIM=1):
- sin_A=-3, sin_B=0 -> m_tdata = -1;
- sin_A=0x7FFF, sin_B=0x7FFF -> 0x7FFF;
- sin_A=0x8000, sin_B=0x8000 -> 0x8000.
REQ-032 Back-pressure check (DECIM=1, m_tready=0):
- stimulus: 4 pairs with values 1,2,3,4;
- required: overrun=1, drop_cnt=2;
- then m_tready=1 -> transfers 1, 2 only.
REQ-033 Alignment check: a_tvalid=1 with b_tvalid=0 for one cycle -> align_err=1 and phase counter unchanged, so the next output still falls on the 5th accepted pair.
REQ-034 Clear/set race: err_clr=1 in the same cycle as a drop -> overrun=1, drop_cnt=1.
REQ-035 Mid-stream reset: RSTN low for 3 cycles with 1 sample buffered -> m_tvalid=0 immediately; after release, the next output follows the 5th new pair.
